sprite_fetch_renderer: RTL and testbench

//  Read-side client of a synchronous sprite ROM (1-cycle read latency, 9-bit RGB333 per pixel).

---
 rtl/sprite_fetch_renderer_if.sv | 34 +++
 rtl/sprite_fetch_renderer.sv | 104 ++++++++++
 tb/tb_sprite_fetch_renderer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_fetch_renderer_if.sv
// Bundle of pixel-timing, shadow-request, sprite-ROM and mixer-facing signals
// shared between the sprite renderer and its surroundings.
interface sprite_fetch_renderer_if;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_valid;
    logic       frame_start;
    logic [9:0] pos_x_in;
    logic [9:0] pos_y_in;
    logic       flip_x_in;
    logic [9:0] sprite_addr;
    logic [8:0] sprite_data;
    logic [8:0] rgb_out;
    logic       rgb_valid;
    logic       hit;

    // Environment side: timing generator, CPU position request, ROM and mixer.
    modport master (
        output pix_x, pix_y, pix_valid, frame_start,
        output pos_x_in, pos_y_in, flip_x_in,
        input  sprite_addr,
        output sprite_data,
        input  rgb_out, rgb_valid, hit
    );

    // Renderer side.
    modport slave (
        input  pix_x, pix_y, pix_valid, frame_start,
        input  pos_x_in, pos_y_in, flip_x_in,
        output sprite_addr,
        input  sprite_data,
        output rgb_out, rgb_valid, hit
    );
endinterface

// File: rtl/sprite_fetch_renderer.sv
// Sprite fetch/render pipeline: turns VGA pixel coordinates into sprite ROM
// addresses, waits out the 1-cycle ROM latency, applies the transparency key
// and presents registered RGB333 plus a hit flag three clocks after the pixel.
// SPRITE_W and SPRITE_H must be powers of two of at least 2.
module sprite_fetch_renderer #(
    parameter int         SPRITE_W    = 32,
    parameter int         SPRITE_H    = 32,
    parameter logic [8:0] TRANSPARENT = 9'b111000111
) (
    input logic CLK,
    input logic RST,
    sprite_fetch_renderer_if.slave bus
);
    localparam int          XB    = $clog2(SPRITE_W);
    localparam int          YB    = $clog2(SPRITE_H);
    localparam logic [10:0] W_LIM = 11'(SPRITE_W);
    localparam logic [10:0] H_LIM = 11'(SPRITE_H);

    logic [9:0]    pos_x;
    logic [9:0]    pos_y;
    logic          flip;
    logic [10:0]   dx;
    logic [10:0]   dy;
    logic          in_box;
    logic [XB-1:0] col;
    logic [9:0]    addr_next;
    logic          in_box_d1;
    logic          in_box_d2;
    logic          valid_d1;
    logic          valid_d2;
    logic          hit_next;

    // Shadow copy of position/flip, only refreshed at vertical blank so a
    // sprite move never tears the frame being drawn.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pos_x <= '0;
            pos_y <= '0;
            flip  <= 1'b0;
        end else if (bus.frame_start) begin
            pos_x <= bus.pos_x_in;
            pos_y <= bus.pos_y_in;
            flip  <= bus.flip_x_in;
        end
    end

    // Box test and address math; bit 10 of dx/dy is the borrow that marks a
    // pixel left of or above the sprite. Mirroring SPRITE_W-1-dx on a
    // power-of-two width is just the bitwise inverse of the low bits, and
    // dy*SPRITE_W is a concatenation.
    always_comb begin
        dx        = {1'b0, bus.pix_x} - {1'b0, pos_x};
        dy        = {1'b0, bus.pix_y} - {1'b0, pos_y};
        in_box    = bus.pix_valid & ~dx[10] & (dx < W_LIM) & ~dy[10] & (dy < H_LIM);
        col       = flip ? ~dx[XB-1:0] : dx[XB-1:0];
        addr_next = '0;
        if (in_box) begin
            addr_next[XB+YB-1:0] = {dy[YB-1:0], col};
        end
    end

    // Stage 0 register: address to the ROM plus the flags that ride along.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.sprite_addr <= '0;
            in_box_d1       <= 1'b0;
            valid_d1        <= 1'b0;
        end else begin
            bus.sprite_addr <= addr_next;
            in_box_d1       <= in_box;
            valid_d1        <= bus.pix_valid;
        end
    end

    // Stage 1 register: flags wait one more clock while the ROM reads.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_box_d2 <= 1'b0;
            valid_d2  <= 1'b0;
        end else begin
            in_box_d2 <= in_box_d1;
            valid_d2  <= valid_d1;
        end
    end

    // A pixel only counts when it is inside the box and not the key colour.
    always_comb begin
        hit_next = in_box_d2 & (bus.sprite_data != TRANSPARENT);
    end

    // Stage 2 register: colour is forced to black whenever there is no hit so
    // the mixer can OR or select without extra gating.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.rgb_out   <= '0;
            bus.rgb_valid <= 1'b0;
            bus.hit       <= 1'b0;
        end else begin
            bus.rgb_out   <= hit_next ? bus.sprite_data : 9'd0;
            bus.rgb_valid <= valid_d2;
            bus.hit       <= hit_next;
        end
    end
endmodule

// File: tb/tb_sprite_fetch_renderer.sv
// Directed bench for sprite_fetch_renderer: a table of single-pixel vectors
// plus hand-written sequences for reset, shadow latching, flip, screen edges
// and back-to-back throughput. The ROM holds rom[i] = i, except rom[0] = 1FF;
// address 455 (9'h1C7) therefore holds the transparency key.
module tb_sprite_fetch_renderer;
    logic CLK;
    logic RST;
    int   test_count;
    int   fail_count;
    logic [8:0] rom [0:1023];

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       valid;
        logic [9:0] exp_addr;
        logic       exp_hit;
        logic [8:0] exp_rgb;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [10];

    sprite_fetch_renderer_if bus ();

    sprite_fetch_renderer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Free-running 100 MHz clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous sprite ROM with one cycle of read latency.
    always @(posedge CLK) begin
        bus.sprite_data <= rom[bus.sprite_addr];
    end

    function automatic vec_t mk(input logic [9:0] x, input logic [9:0] y, input logic v,
                                input logic [9:0] a, input logic h, input logic [8:0] c,
                                input logic ov);
        vec_t r;
        r.x = x; r.y = y; r.valid = v;
        r.exp_addr = a; r.exp_hit = h; r.exp_rgb = c; r.exp_valid = ov;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic v);
        @(negedge CLK);
        bus.pix_x     = x;
        bus.pix_y     = y;
        bus.pix_valid = v;
    endtask

    task automatic pulseFrameStart(input logic [9:0] x, input logic [9:0] y, input logic f);
        @(negedge CLK);
        bus.pos_x_in    = x;
        bus.pos_y_in    = y;
        bus.flip_x_in   = f;
        bus.frame_start = 1'b1;
        bus.pix_valid   = 1'b0;
        @(negedge CLK);
        bus.frame_start = 1'b0;
    endtask

    // One isolated pixel: address checked after edge E0, outputs after E2.
    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v.x, v.y, v.valid);
        @(posedge CLK); #1;
        checkOutput({tag, " addr"}, 32'(bus.sprite_addr), 32'(v.exp_addr));
        @(negedge CLK);
        bus.pix_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1;
        checkOutput({tag, " hit"}, 32'(bus.hit), 32'(v.exp_hit));
        checkOutput({tag, " rgb"}, 32'(bus.rgb_out), 32'(v.exp_rgb));
        checkOutput({tag, " rgb_valid"}, 32'(bus.rgb_valid), 32'(v.exp_valid));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " addr"}, 32'(bus.sprite_addr), 32'd0);
        checkOutput({tag, " rgb"}, 32'(bus.rgb_out), 32'd0);
        checkOutput({tag, " rgb_valid"}, 32'(bus.rgb_valid), 32'd0);
        checkOutput({tag, " hit"}, 32'(bus.hit), 32'd0);
    endtask

    // Main test sequence.
    initial begin
        logic [8:0] exp_rgb;
        test_count = 0;
        fail_count = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 9'(i);
        rom[0] = 9'h1FF;

        // Sprite at 100,50, no flip.
        vecs[0] = mk(10'd100, 10'd50, 1'b1, 10'd0,    1'b1, 9'h1FF, 1'b1);
        vecs[1] = mk(10'd131, 10'd81, 1'b1, 10'd1023, 1'b1, 9'h1FF, 1'b1);
        vecs[2] = mk(10'd132, 10'd50, 1'b1, 10'd0,    1'b0, 9'h000, 1'b1);
        vecs[3] = mk(10'd99,  10'd50, 1'b1, 10'd0,    1'b0, 9'h000, 1'b1);
        vecs[4] = mk(10'd107, 10'd64, 1'b1, 10'd455,  1'b0, 9'h000, 1'b1);
        vecs[5] = mk(10'd110, 10'd60, 1'b0, 10'd0,    1'b0, 9'h000, 1'b0);
        vecs[6] = mk(10'd100, 10'd49, 1'b1, 10'd0,    1'b0, 9'h000, 1'b1);
        vecs[7] = mk(10'd100, 10'd82, 1'b1, 10'd0,    1'b0, 9'h000, 1'b1);
        vecs[8] = mk(10'd105, 10'd53, 1'b1, 10'd101,  1'b1, 9'd101,  1'b1);
        vecs[9] = mk(10'd0,   10'd0,  1'b1, 10'd0,    1'b0, 9'h000, 1'b1);

        RST             = 1'b1;
        bus.pix_x       = '0;
        bus.pix_y       = '0;
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.pos_x_in    = '0;
        bus.pos_y_in    = '0;
        bus.flip_x_in   = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        checkAllZero("reset_init");
        @(negedge CLK);
        RST = 1'b0;

        // Stream an in-box pixel, then hit reset mid-stream.
        pulseFrameStart(10'd100, 10'd50, 1'b0);
        applyStimulus(10'd100, 10'd50, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("prereset hit", 32'(bus.hit), 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checkAllZero("async_reset");
        @(posedge CLK); #1;
        checkAllZero("held_reset");
        @(negedge CLK);
        bus.pix_valid = 1'b0;
        RST = 1'b0;

        // Shadow was cleared by reset, so reload it, then time the first hit.
        pulseFrameStart(10'd100, 10'd50, 1'b0);
        applyStimulus(10'd100, 10'd50, 1'b1);
        @(posedge CLK); #1;
        checkOutput("lat E0 hit", 32'(bus.hit), 32'd0);
        @(negedge CLK);
        bus.pix_valid = 1'b0;
        @(posedge CLK); #1;
        checkOutput("lat E1 hit", 32'(bus.hit), 32'd0);
        @(posedge CLK); #1;
        checkOutput("lat E2 hit", 32'(bus.hit), 32'd1);
        checkOutput("lat E2 rgb", 32'(bus.rgb_out), 32'h1FF);

        for (int i = 0; i < 10; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Horizontal mirror.
        pulseFrameStart(10'd100, 10'd50, 1'b1);
        runVector(mk(10'd100, 10'd51, 1'b1, 10'd63, 1'b1, 9'h03F, 1'b1), "flip 100,51");
        runVector(mk(10'd131, 10'd50, 1'b1, 10'd0,  1'b1, 9'h1FF, 1'b1), "flip 131,50");

        // Position request changes mid-frame are ignored until frame_start.
        pulseFrameStart(10'd100, 10'd50, 1'b0);
        @(negedge CLK);
        bus.pos_x_in = 10'd200;
        runVector(mk(10'd100, 10'd50, 1'b1, 10'd0, 1'b1, 9'h1FF, 1'b1), "hold old pos");
        pulseFrameStart(10'd200, 10'd50, 1'b0);
        runVector(mk(10'd100, 10'd50, 1'b1, 10'd0, 1'b0, 9'h000, 1'b1), "new pos miss");
        runVector(mk(10'd200, 10'd50, 1'b1, 10'd0, 1'b1, 9'h1FF, 1'b1), "new pos hit");

        // frame_start coinciding with a pixel: that pixel uses the old shadow.
        @(negedge CLK);
        bus.pos_x_in    = 10'd300;
        bus.frame_start = 1'b1;
        bus.pix_x       = 10'd205;
        bus.pix_y       = 10'd50;
        bus.pix_valid   = 1'b1;
        @(posedge CLK); #1;
        checkOutput("fs same cycle addr", 32'(bus.sprite_addr), 32'd5);
        @(negedge CLK);
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1;
        checkOutput("fs same cycle rgb", 32'(bus.rgb_out), 32'd5);
        runVector(mk(10'd305, 10'd50, 1'b1, 10'd5, 1'b1, 9'd5, 1'b1), "after fs 305");

        // Sprite hanging past the bottom-right corner of the screen.
        pulseFrameStart(10'd620, 10'd470, 1'b0);
        runVector(mk(10'd639, 10'd479, 1'b1, 10'd307, 1'b1, 9'h133, 1'b1), "corner 639,479");
        runVector(mk(10'd620, 10'd470, 1'b1, 10'd0,   1'b1, 9'h1FF, 1'b1), "corner 620,470");
        runVector(mk(10'd619, 10'd470, 1'b1, 10'd0,   1'b0, 9'h000, 1'b1), "corner 619,470");

        // Back-to-back pixels: one result per clock, 3-cycle latency.
        pulseFrameStart(10'd100, 10'd50, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (k < 4) begin
                bus.pix_x     = 10'(100 + k);
                bus.pix_y     = 10'd50;
                bus.pix_valid = 1'b1;
            end else begin
                bus.pix_valid = 1'b0;
            end
            @(posedge CLK); #1;
            if (k >= 2) begin
                exp_rgb = (k == 2) ? 9'h1FF : 9'(k - 2);
                checkOutput($sformatf("stream%0d rgb", k - 2), 32'(bus.rgb_out), 32'(exp_rgb));
                checkOutput($sformatf("stream%0d hit", k - 2), 32'(bus.hit), 32'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end
endmodule
